note_seq_ctrl: RTL and testbench

Controller that sequences the tone-generation datapath of the music lab. It accepts notes over a valid/ready handshake and latches each note's half-period, duration and last flag into enabled registers. It runs a half-period counter that toggles a square-wave audio output, and a tick-driven duration counter. Each note is followed by a fixed silent gap, and `done` is signalled at the end of a song.

---
 rtl/note_seq_ctrl_if.sv | 28 ++
 rtl/note_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_note_seq_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/note_seq_ctrl_if.sv
// rtl/note_seq_ctrl_if.sv - note handshake bundle between note source and sequencer
// The master presents notes and the slave (the sequencer) reports readiness.
interface note_seq_ctrl_if #(
  parameter int PERIOD_W = 16,
  parameter int DUR_W    = 8
);
  logic                note_val;
  logic                note_rdy;
  logic [PERIOD_W-1:0] note_period;
  logic [DUR_W-1:0]    note_dur;
  logic                note_last;

  modport master (
    output note_val,
    output note_period,
    output note_dur,
    output note_last,
    input  note_rdy
  );

  modport slave (
    input  note_val,
    input  note_period,
    input  note_dur,
    input  note_last,
    output note_rdy
  );
endinterface

// File: rtl/note_seq_ctrl.sv
// rtl/note_seq_ctrl.sv - note sequencer driving a square-wave tone with per-note silent gap
// Accepts notes in IDLE, plays them for a tick-counted duration, then inserts a fixed gap.
module note_seq_ctrl #(
  parameter int PERIOD_W   = 16,
  parameter int DUR_W      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  note_seq_ctrl_if.slave  note_if,
  input  logic            tick,
  input  logic            stop,
  output logic            audio_out,
  output logic            playing,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0]          GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] P_ONE    = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [DUR_W-1:0]    D_ONE    = {{(DUR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] hp_cnt_q, hp_cnt_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic                last_q, last_d;
  logic [7:0]          gap_cnt_q, gap_cnt_d;
  logic                audio_q, audio_d;
  logic                done_q, done_d;
  logic                accept;

  // Readiness depends only on state, so note_val never loops back into note_rdy.
  assign note_if.note_rdy = (state_q == IDLE);
  assign accept           = note_if.note_val && (state_q == IDLE) && !stop;

  assign audio_out = audio_q;
  assign done      = done_q;
  assign playing   = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    hp_cnt_d  = hp_cnt_q;
    dur_cnt_d = dur_cnt_q;
    last_d    = last_q;
    gap_cnt_d = gap_cnt_q;
    audio_d   = audio_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        audio_d = 1'b0;
        if (accept) begin
          period_d  = note_if.note_period;
          last_d    = note_if.note_last;
          hp_cnt_d  = '0;
          dur_cnt_d = note_if.note_dur;
          gap_cnt_d = '0;
          state_d   = (note_if.note_dur != '0) ? PLAY : GAP;
        end
      end

      PLAY: begin
        if (stop) begin
          state_d   = IDLE;
          audio_d   = 1'b0;
          hp_cnt_d  = '0;
          dur_cnt_d = '0;
          gap_cnt_d = '0;
        end else if (tick && (dur_cnt_q == D_ONE)) begin
          state_d   = GAP;
          audio_d   = 1'b0;
          hp_cnt_d  = '0;
          dur_cnt_d = '0;
          gap_cnt_d = '0;
        end else begin
          if (tick) begin
            dur_cnt_d = dur_cnt_q - D_ONE;
          end
          // A zero period is a rest: the output stays low for the whole note.
          if (period_q == '0) begin
            audio_d  = 1'b0;
            hp_cnt_d = '0;
          end else if (hp_cnt_q == (period_q - P_ONE)) begin
            audio_d  = ~audio_q;
            hp_cnt_d = '0;
          end else begin
            hp_cnt_d = hp_cnt_q + P_ONE;
          end
        end
      end

      GAP: begin
        audio_d = 1'b0;
        if (stop) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
          done_d    = last_q;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        audio_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      period_q  <= '0;
      hp_cnt_q  <= '0;
      dur_cnt_q <= '0;
      last_q    <= 1'b0;
      gap_cnt_q <= '0;
      audio_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      hp_cnt_q  <= hp_cnt_d;
      dur_cnt_q <= dur_cnt_d;
      last_q    <= last_d;
      gap_cnt_q <= gap_cnt_d;
      audio_q   <= audio_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_note_seq_ctrl.sv
// tb/tb_note_seq_ctrl.sv - self-checking bench for note_seq_ctrl
// Expected waveforms come from per-note arithmetic over the bench's own tick schedule.
module tb_note_seq_ctrl;

  localparam int PW  = 16;
  localparam int DW  = 8;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic stop;
  logic audio_out;
  logic playing;
  logic done;
  logic exp_done;

  int n_tests = 0;
  int n_fail  = 0;

  note_seq_ctrl_if #(.PERIOD_W(PW), .DUR_W(DW)) nif ();

  note_seq_ctrl #(
    .PERIOD_W  (PW),
    .DUR_W     (DW),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .note_if  (nif.slave),
    .tick     (tick),
    .stop     (stop),
    .audio_out(audio_out),
    .playing  (playing),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_rdy"},   32'(nif.note_rdy), 32'd1);
    chk({tag, "_play"},  32'(playing),      32'd0);
    chk({tag, "_audio"}, 32'(audio_out),    32'd0);
    chk({tag, "_done"},  32'(done),         32'(exp_done));
  endtask

  // Square wave seen in the k-th PLAY cycle (1-based): flips after every per cycles.
  function automatic logic exp_audio(input int per, input int k);
    if (per == 0) return 1'b0;
    return 1'(((k - 1) / per) % 2);
  endfunction

  task automatic scramble_fields();
    nif.note_period = PW'($urandom);
    nif.note_dur    = DW'($urandom);
    nif.note_last   = 1'($urandom);
  endtask

  task automatic play_note(input string tag, input int per, input int dur, input bit last,
                           input int tint, input bit hold);
    int ticks = 0;
    int k     = 0;
    @(negedge clk);
    idle_check({tag, "_acc"});
    nif.note_val    = 1'b1;
    nif.note_period = PW'(per);
    nif.note_dur    = DW'(dur);
    nif.note_last   = last;
    tick            = 1'b1;
    stop            = 1'b0;
    while (ticks < dur) begin
      @(negedge clk);
      k++;
      if (hold) scramble_fields(); else nif.note_val = 1'b0;
      chk({tag, "_p_play"},  32'(playing),      32'd1);
      chk({tag, "_p_rdy"},   32'(nif.note_rdy), 32'd0);
      chk({tag, "_p_done"},  32'(done),         32'd0);
      chk({tag, "_p_audio"}, 32'(audio_out),    32'(exp_audio(per, k)));
      tick = ((k % tint) == 0);
      if (tick) ticks++;
    end
    for (int g = 1; g <= GAP; g++) begin
      @(negedge clk);
      if (hold) scramble_fields(); else nif.note_val = 1'b0;
      chk({tag, "_g_play"},  32'(playing),      32'd1);
      chk({tag, "_g_rdy"},   32'(nif.note_rdy), 32'd0);
      chk({tag, "_g_audio"}, 32'(audio_out),    32'd0);
      chk({tag, "_g_done"},  32'(done),         32'd0);
      tick = 1'($urandom);
    end
    tick     = 1'b0;
    exp_done = last;
  endtask

  task automatic abort_note(input string tag, input int per, input int n_play, input bit use_rst);
    @(negedge clk);
    idle_check({tag, "_acc"});
    nif.note_val    = 1'b1;
    nif.note_period = PW'(per);
    nif.note_dur    = DW'(10);
    nif.note_last   = 1'b1;
    tick            = 1'b0;
    for (int k = 1; k <= n_play; k++) begin
      @(negedge clk);
      nif.note_val = 1'b0;
      chk({tag, "_p_play"},  32'(playing),   32'd1);
      chk({tag, "_p_audio"}, 32'(audio_out), 32'(exp_audio(per, k)));
    end
    if (use_rst) rst = 1'b1; else stop = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    stop     = 1'b0;
    exp_done = 1'b0;
    idle_check({tag, "_after"});
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    idle_check(tag);
    nif.note_val = 1'b0;
    exp_done     = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    tick            = 1'b0;
    stop            = 1'b0;
    exp_done        = 1'b0;
    nif.note_val    = 1'b1;
    nif.note_period = PW'(3);
    nif.note_dur    = DW'(1);
    nif.note_last   = 1'b1;

    // Reset held two cycles with a note offered: nothing may be taken.
    repeat (2) @(negedge clk);
    chk("rst_play", 32'(playing),      32'd0);
    chk("rst_rdy",  32'(nif.note_rdy), 32'd1);
    rst          = 1'b0;
    nif.note_val = 1'b0;
    @(negedge clk);
    idle_check("post_rst");

    // stop in IDLE blocks the transfer.
    nif.note_val = 1'b1;
    stop         = 1'b1;
    @(negedge clk);
    chk("idle_stop_play", 32'(playing),      32'd0);
    chk("idle_stop_rdy",  32'(nif.note_rdy), 32'd1);
    nif.note_val = 1'b0;
    stop         = 1'b0;

    play_note("t2", 3, 2, 1'b1, 20, 1'b0);
    play_note("t3", 0, 1, 1'b0, 5, 1'b0);
    play_note("t4", 7, 0, 1'b0, 1, 1'b0);
    abort_note("t5s", 5, 12, 1'b0);
    abort_note("t5r", 5, 12, 1'b1);

    play_note("t6a", 2, 1, 1'b0, 13, 1'b1);
    play_note("t6b", 4, 1, 1'b0, 13, 1'b1);
    play_note("t6c", 6, 1, 1'b1, 13, 1'b1);
    idle_cycle("t6_end");

    for (int i = 0; i < 6; i++) begin
      abort_note("rnd_abort", int'($urandom_range(1, 6)), int'($urandom_range(1, 20)),
                 1'($urandom));
    end

    for (int i = 0; i < 24; i++) begin
      play_note("rnd", int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
                1'($urandom), int'($urandom_range(1, 6)), 1'($urandom));
    end
    idle_cycle("rnd_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
